// File: rtl/jtdd2_snd_romarb_if.sv
// Sound-side ROM buses and the SDRAM read slot used by jtdd2_snd_romarb.
// The slave modport is the arbiter; the master modport is the environment around it.
interface jtdd2_snd_romarb_if #(
   parameter int unsigned MAW = 19
);
   logic           cpu_cs;
   logic [14:0]    cpu_addr;
   logic [7:0]     cpu_data;
   logic           cpu_ok;
   logic           pcm_cs;
   logic [17:0]    pcm_addr;
   logic [7:0]     pcm_data;
   logic           pcm_ok;
   logic           mem_req;
   logic [MAW-1:0] mem_addr;
   logic           mem_rdy;
   logic [7:0]     mem_data;

   modport slave (
      input  cpu_cs, cpu_addr, pcm_cs, pcm_addr, mem_rdy, mem_data,
      output cpu_data, cpu_ok, pcm_data, pcm_ok, mem_req, mem_addr
   );

   modport master (
      output cpu_cs, cpu_addr, pcm_cs, pcm_addr, mem_rdy, mem_data,
      input  cpu_data, cpu_ok, pcm_data, pcm_ok, mem_req, mem_addr
   );
endinterface

// File: rtl/jtdd2_snd_romarb.sv
// Shares one SDRAM byte read slot between the Z80 program ROM and the ADPCM ROM.
// Each requester has a one-entry cache; misses are fetched in round-robin order.
module jtdd2_snd_romarb #(
   parameter int unsigned    MAW        = 19,
   parameter logic [MAW-1:0] CPU_OFFSET = 'h00000,
   parameter logic [MAW-1:0] PCM_OFFSET = 'h08000
) (
   input  logic                  clk,
   input  logic                  rst,
   jtdd2_snd_romarb_if.slave     bus
);
   typedef enum logic [1:0] {IDLE, FETCH_CPU, FETCH_PCM} state_t;

   state_t         state;
   logic [14:0]    cpu_tag;
   logic [17:0]    pcm_tag;
   logic [17:0]    fetch_tag;
   logic [7:0]     cpu_data, pcm_data;
   logic           cpu_val, pcm_val;
   logic           last_pcm;
   logic           mem_req;
   logic [MAW-1:0] mem_addr;

   logic hit_cpu, hit_pcm, miss_cpu, miss_pcm, pick_cpu;

   assign hit_cpu  = bus.cpu_cs & cpu_val & (cpu_tag == bus.cpu_addr);
   assign hit_pcm  = bus.pcm_cs & pcm_val & (pcm_tag == bus.pcm_addr);
   assign miss_cpu = bus.cpu_cs & ~hit_cpu;
   assign miss_pcm = bus.pcm_cs & ~hit_pcm;
   // CPU wins when alone, or on contention if PCM was served last
   assign pick_cpu = miss_cpu & (~miss_pcm | last_pcm);

   assign bus.cpu_ok   = hit_cpu;
   assign bus.pcm_ok   = hit_pcm;
   assign bus.cpu_data = cpu_data;
   assign bus.pcm_data = pcm_data;
   assign bus.mem_req  = mem_req;
   assign bus.mem_addr = mem_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         cpu_tag   <= '0;
         pcm_tag   <= '0;
         fetch_tag <= '0;
         cpu_data  <= '0;
         pcm_data  <= '0;
         cpu_val   <= 1'b0;
         pcm_val   <= 1'b0;
         last_pcm  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (pick_cpu) begin
                  state     <= FETCH_CPU;
                  mem_req   <= 1'b1;
                  mem_addr  <= CPU_OFFSET + MAW'(bus.cpu_addr);
                  fetch_tag <= 18'(bus.cpu_addr);
               end else if (miss_pcm) begin
                  state     <= FETCH_PCM;
                  mem_req   <= 1'b1;
                  mem_addr  <= PCM_OFFSET + MAW'(bus.pcm_addr);
                  fetch_tag <= bus.pcm_addr;
               end
            end
            // Fetch always completes, even if the address moved or cs dropped
            FETCH_CPU: begin
               if (bus.mem_rdy) begin
                  cpu_data <= bus.mem_data;
                  cpu_tag  <= fetch_tag[14:0];
                  cpu_val  <= 1'b1;
                  mem_req  <= 1'b0;
                  last_pcm <= 1'b0;
                  state    <= IDLE;
               end
            end
            FETCH_PCM: begin
               if (bus.mem_rdy) begin
                  pcm_data <= bus.mem_data;
                  pcm_tag  <= fetch_tag;
                  pcm_val  <= 1'b1;
                  mem_req  <= 1'b0;
                  last_pcm <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end
endmodule
